percep_wght_bank: RTL and testbench
===================================

Name: percep_wght_bank

Overview:
- Next-generation perceptron weight store: parametrised depth/width, dual-address (independent write and read ports), registered reads with a valid flag, and a self-clearing initialisation sweep.
- Burst mode streams the ATTR weights w0..w(ATTR-1) on consecutive cycles to the MAC/update pipeline.
- Sits between the training controller (writes updated weights) and the dot-product datapath (consumes weight bursts).

Parameters:
ATTR, 5, number of weights per burst (w0..w(ATTR-1)); must be <= MEM_DEPTH
MEM_ADDR_WGHT, 3, address width; MEM_DEPTH = 2**MEM_ADDR_WGHT
FP_WIDTH, 16, fixed-point data width
INIT_VAL, {FP_WIDTH{1'b0}}, value written to every entry by the init sweep

Ports:
clk  input  1  clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
cs  input  1  chip select; gates we, oe, burst_start
we  input  1  write enable
wr_addr  input  MEM_ADDR_WGHT  write address
d_in  input  FP_WIDTH  write data
oe  input  1  single-read request
rd_addr  input  MEM_ADDR_WGHT  single-read address
burst_start  input  1  start ATTR-long burst from address 0
clr  input  1  re-run init sweep
d_out  output  FP_WIDTH  registered read data
d_valid  output  1  d_out holds valid data this cycle
d_last  output  1  final beat of a burst
busy  output  1  init sweep or burst in progress

Behaviour:
- Reset (rst_n=0 at posedge): state<=INIT, sweep counter<=0, d_out<=0, d_valid<=0, d_last<=0, busy<=1. Memory contents are not reset directly; the sweep clears them.
- FSM states: INIT, IDLE, BURST.
- INIT:
  - Each cycle writes INIT_VAL to mem[cnt], then cnt++.
  - After writing MEM_DEPTH-1, go to IDLE. The sweep takes exactly MEM_DEPTH cycles; busy=1 throughout.
  - External we/oe/burst_start are ignored (writes dropped, d_valid=0).
- IDLE: busy=0.
  - cs&we: mem[wr_addr]<=d_in.
  - cs&oe: next cycle d_out=mem[rd_addr], d_valid=1 (latency 1). Otherwise d_valid=0 and d_out holds its last value.
- Read-during-write on the same address (single read or burst beat): write-first. d_out returns d_in of that cycle.
- BURST:
  - Entered from IDLE on cs&burst_start. busy=1 from the cycle after acceptance until d_last.
  - Beat k (k=0..ATTR-1) presents mem[k] on d_out with d_valid=1, k+1 cycles after burst_start.
  - d_last=1 with beat ATTR-1; the FSM then returns to IDLE.
  - Writes are accepted during BURST with write-first bypass. A write to an address not yet streamed is visible in that later beat.
  - oe and burst_start are ignored during BURST.
- clr: when cs&clr in IDLE or BURST, go to INIT with cnt=0 on the next cycle. An in-flight burst is aborted: d_valid and d_last drop to 0 and no further beats are issued.
- Priority in the same cycle: rst_n > clr > burst_start > oe. we and oe in the same cycle are both serviced.
- Counters: burst counter width clog2(ATTR); sweep counter MEM_ADDR_WGHT+1 bits so the terminal count is detectable without wrap.
- Addresses are unsigned and always in range (depth is a power of 2).

Decomposition:
- Shared package/header (percep_pkg): FSM state encodings (INIT=2'd0, IDLE=2'd1, BURST=2'd2), FP_WIDTH, ATTR, MEM_ADDR_WGHT defaults, clog2 function.
- One sub-module is natural: percep_wght_ram, a simple 1W/1R synchronous RAM array with registered read. The top level holds the FSM, counters, write-first bypass mux and port arbitration.

Test Plan:
- Reset, then idle for 8 cycles (depth 8) -> busy=1 for exactly 8 cycles, then 0; single reads of all addresses return 16'h0000 with d_valid one cycle after oe.
- Write 16'h1234 to addr 2, then oe at addr 2 next cycle -> d_out=16'h1234, d_valid=1 exactly one cycle later.
- Same-cycle we+oe at addr 3 with d_in=16'hABCD -> next cycle d_out=16'hABCD (write-first).
- Preload w0..w4=1..5, pulse burst_start -> d_out 1,2,3,4,5 on 5 consecutive cycles; d_valid high for 5 cycles; d_last only on value 5; busy low afterwards.
- During a burst, write 16'h00FF to addr 4 while beat 1 is out -> beat 4 = 16'h00FF; oe asserted mid-burst produces no extra d_valid.
- clr asserted at burst beat 2 -> d_valid=0 the next cycle, busy=1 for 8 cycles, all entries read back 0; rst_n=0 mid-sweep -> sweep restarts from cnt=0 (busy stays high for a full 8 cycles after release).

Source files
------------

// File: rtl/percep_pkg.sv
// Shared types and defaults for the perceptron weight bank: FSM encoding,
// default geometry and a constant-foldable clog2.
package percep_pkg;

   localparam int ATTR_DEF          = 5;
   localparam int MEM_ADDR_WGHT_DEF = 3;
   localparam int FP_WIDTH_DEF      = 16;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BURST = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/percep_wght_ram.sv
// Simple 1W/1R synchronous RAM with registered, enable-gated read.
// A same-address read returns the old contents; the caller bypasses.
module percep_wght_ram #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] rd_data_reg;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_reg <= mem[rd_addr];
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/percep_wght_bank.sv
// Perceptron weight store: init sweep, single reads and ATTR-beat bursts
// from address 0, with write-first bypass on every read.
module percep_wght_bank
   import percep_pkg::*;
#(
   parameter int                  ATTR          = ATTR_DEF,
   parameter int                  MEM_ADDR_WGHT = MEM_ADDR_WGHT_DEF,
   parameter int                  FP_WIDTH      = FP_WIDTH_DEF,
   parameter logic [FP_WIDTH-1:0] INIT_VAL      = {FP_WIDTH{1'b0}}
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cs,
   input  logic                     we,
   input  logic [MEM_ADDR_WGHT-1:0] wr_addr,
   input  logic [FP_WIDTH-1:0]      d_in,
   input  logic                     oe,
   input  logic [MEM_ADDR_WGHT-1:0] rd_addr,
   input  logic                     burst_start,
   input  logic                     clr,
   output logic [FP_WIDTH-1:0]      d_out,
   output logic                     d_valid,
   output logic                     d_last,
   output logic                     busy
);

   localparam int MEM_DEPTH = 1 << MEM_ADDR_WGHT;
   localparam int CNT_W     = MEM_ADDR_WGHT + 1;
   localparam int BCNT_W    = (clog2(ATTR) < 1) ? 1 : clog2(ATTR);

   state_t                   state_reg;
   logic [CNT_W-1:0]         cnt_reg;
   logic [BCNT_W-1:0]        bcnt_reg;
   logic                     d_valid_reg;
   logic                     d_last_reg;
   logic                     busy_reg;
   logic                     byp_sel_reg;
   logic [FP_WIDTH-1:0]      byp_data_reg;

   logic                     wr_en;
   logic [MEM_ADDR_WGHT-1:0] wr_addr_mux;
   logic [FP_WIDTH-1:0]      wr_data_mux;
   logic                     rd_en;
   logic [MEM_ADDR_WGHT-1:0] rd_addr_mux;
   logic                     rd_hit;
   logic [FP_WIDTH-1:0]      ram_q;

   // Port arbitration: the sweep owns the write port; reads follow clr > burst_start > oe.
   always_comb begin
      wr_en       = 1'b0;
      wr_addr_mux = wr_addr;
      wr_data_mux = d_in;
      rd_en       = 1'b0;
      rd_addr_mux = rd_addr;
      case (state_reg)
         ST_INIT: begin
            wr_en       = 1'b1;
            wr_addr_mux = cnt_reg[MEM_ADDR_WGHT-1:0];
            wr_data_mux = INIT_VAL;
         end
         ST_IDLE: begin
            wr_en = cs & we;
            if (cs && !clr) begin
               if (burst_start) begin
                  rd_en       = 1'b1;
                  rd_addr_mux = '0;
               end else if (oe) begin
                  rd_en = 1'b1;
               end
            end
         end
         ST_BURST: begin
            wr_en = cs & we;
            if (!(cs && clr)) begin
               rd_en       = 1'b1;
               rd_addr_mux = MEM_ADDR_WGHT'(bcnt_reg);
            end
         end
         default: ;
      endcase
      rd_hit = wr_en && (wr_addr_mux == rd_addr_mux);
   end

   percep_wght_ram #(
      .ADDR_W (MEM_ADDR_WGHT),
      .DATA_W (FP_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr_mux),
      .wr_data (wr_data_mux),
      .rd_en   (rd_en),
      .rd_addr (rd_addr_mux),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_INIT;
         cnt_reg      <= '0;
         bcnt_reg     <= '0;
         d_valid_reg  <= 1'b0;
         d_last_reg   <= 1'b0;
         busy_reg     <= 1'b1;
         byp_sel_reg  <= 1'b1;
         byp_data_reg <= '0;
      end else begin
         // Bypass select only moves with a read, so d_out holds between reads.
         if (rd_en) begin
            byp_sel_reg  <= rd_hit;
            byp_data_reg <= wr_data_mux;
         end
         d_valid_reg <= rd_en;
         d_last_reg  <= 1'b0;
         case (state_reg)
            ST_INIT: begin
               busy_reg <= 1'b1;
               cnt_reg  <= cnt_reg + 1'b1;
               if (cnt_reg == CNT_W'(MEM_DEPTH - 1)) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            ST_IDLE: begin
               busy_reg <= 1'b0;
               if (cs && clr) begin
                  state_reg <= ST_INIT;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
               end else if (cs && burst_start) begin
                  busy_reg <= 1'b1;
                  bcnt_reg <= BCNT_W'(1);
                  if (ATTR == 1) d_last_reg <= 1'b1;
                  else           state_reg  <= ST_BURST;
               end
            end
            ST_BURST: begin
               busy_reg <= 1'b1;
               if (cs && clr) begin
                  state_reg <= ST_INIT;
                  cnt_reg   <= '0;
               end else begin
                  bcnt_reg <= bcnt_reg + 1'b1;
                  if (bcnt_reg == BCNT_W'(ATTR - 1)) begin
                     d_last_reg <= 1'b1;
                     state_reg  <= ST_IDLE;
                  end
               end
            end
            default: begin
               state_reg <= ST_INIT;
               cnt_reg   <= '0;
               busy_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign d_out   = byp_sel_reg ? byp_data_reg : ram_q;
   assign d_valid = d_valid_reg;
   assign d_last  = d_last_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_percep_wght_bank.sv
// Directed bench for percep_wght_bank: reads are scored against a queue of
// expected beats, each tagged with the cycle it must appear in.
module tb_percep_wght_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [15:0] d_in = '0;
   logic        oe = 1'b0;
   logic [2:0]  rd_addr = '0;
   logic        burst_start = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] d_out;
   logic        d_valid;
   logic        d_last;
   logic        busy;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mdl [0:7];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   percep_wght_bank dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cs          (cs),
      .we          (we),
      .wr_addr     (wr_addr),
      .d_in        (d_in),
      .oe          (oe),
      .rd_addr     (rd_addr),
      .burst_start (burst_start),
      .clr         (clr),
      .d_out       (d_out),
      .d_valid     (d_valid),
      .d_last      (d_last),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input logic [15:0] data, input logic last);
      exp_t e;
      e.data = data;
      e.last = last;
      e.due  = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                        input logic o, input logic [2:0] ra, input logic bs, input logic cl);
      cs = 1'b1; we = w; wr_addr = wa; d_in = wd;
      oe = o; rd_addr = ra; burst_start = bs; clr = cl;
      tick();
      cs = 1'b0; we = 1'b0; oe = 1'b0; burst_start = 1'b0; clr = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      mdl[a] = d;
      drive(1'b1, a, d, 1'b0, 3'd0, 1'b0, 1'b0);
   endtask

   task automatic read_all();
      for (int a = 0; a < 8; a++) begin
         exp_push(mdl[a], 1'b0);
         drive(1'b0, 3'd0, 16'h0, 1'b1, 3'(a), 1'b0, 1'b0);
      end
      idle();
   endtask

   // Sweep after reset release or clr: busy for exactly 8 cycles, then low.
   task automatic sweep_check(input string tag);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk({tag, "_busy_hi"}, busy, 1);
         tick();
      end
      @(negedge clk);
      chk({tag, "_busy_lo"}, busy, 0);
   endtask

   // Scoreboard: a beat must appear exactly in its due cycle and nowhere else.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         chk("rd_valid", d_valid, 1);
         chk("rd_data", d_out, e.data);
         chk("rd_last", d_last, e.last);
         $display("beat cycle=%0d d_out=%h d_last=%b exp=%h/%b", cyc, d_out, d_last, e.data, e.last);
      end else begin
         chk("no_valid", d_valid, 0);
         chk("no_last", d_last, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;

      // Reset state
      tick();
      tick();
      @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_d_out", d_out, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_d_last", d_last, 0);
      tick();
      rst_n = 1'b1;
      sweep_check("init");
      read_all();

      // Write then single read
      wr(3'd2, 16'h1234);
      exp_push(mdl[2], 1'b0);
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 1'b0, 1'b0);
      idle();

      // Same-cycle write and read, write-first
      mdl[3] = 16'hABCD;
      exp_push(16'hABCD, 1'b0);
      drive(1'b1, 3'd3, 16'hABCD, 1'b1, 3'd3, 1'b0, 1'b0);
      idle();

      // Plain burst of 1..5
      for (int k = 0; k < 5; k++) wr(3'(k), 16'(k + 1));
      exp_push(mdl[0], 1'b0);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      for (int k = 1; k < 5; k++) begin
         exp_push(mdl[k], k == 4);
         idle();
      end
      @(negedge clk);
      chk("burst_busy_last", busy, 1);
      tick();
      @(negedge clk);
      chk("burst_busy_after", busy, 0);
      idle();

      // Burst with writes ahead of / onto the streamed address, and an ignored oe
      exp_push(mdl[0], 1'b0);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      exp_push(mdl[1], 1'b0);
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b0, 1'b0);
      mdl[4] = 16'h00FF;
      exp_push(mdl[2], 1'b0);
      drive(1'b1, 3'd4, 16'h00FF, 1'b0, 3'd0, 1'b0, 1'b0);
      mdl[3] = 16'h0333;
      exp_push(16'h0333, 1'b0);
      drive(1'b1, 3'd3, 16'h0333, 1'b1, 3'd1, 1'b0, 1'b0);
      exp_push(16'h00FF, 1'b1);
      idle();
      idle();
      idle();

      // clr while beat 2 is out aborts the burst and re-runs the sweep
      exp_push(mdl[0], 1'b0);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      exp_push(mdl[1], 1'b0);
      idle();
      exp_push(mdl[2], 1'b0);
      idle();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
      sweep_check("clr");
      read_all();

      // Reset in the middle of a sweep restarts it from entry 0
      wr(3'd5, 16'h7777);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1);
      mdl[5] = 16'h0000;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sweep_check("rst_mid");
      read_all();
      idle();
      idle();

      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
